// File: rtl/imem_loader_pkg.sv
// Shared constants for the instruction-memory loader: FSM encoding, word geometry
// and the default address width matching the 64-word instruction memory.
package imem_loader_pkg;

   localparam int unsigned DEFAULT_ADDR_W = 6;
   localparam int unsigned WORD_BYTES     = 4;
   localparam int unsigned WORD_W         = 8 * WORD_BYTES;
   localparam int unsigned BYTE_CNT_W     = $clog2(WORD_BYTES);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_RECV  = 3'd1;
   localparam logic [2:0] ST_WRITE = 3'd2;
   localparam logic [2:0] ST_CHK   = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-to-word assembler; shared by data words and the checksum word.
module imem_loader_byte_packer
   import imem_loader_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic [7:0]            byte_in,
   input  logic                  byte_valid,
   output logic [WORD_W-1:0]     word,
   output logic                  word_ready_c,
   output logic [BYTE_CNT_W-1:0] byte_cnt
);

   always_ff @(posedge clk) begin
      if (rst) begin
         word     <= '0;
         byte_cnt <= '0;
      end else if (clear) begin
         byte_cnt <= '0;
      end else if (byte_valid) begin
         word[{byte_cnt, 3'b000} +: 8] <= byte_in;
         byte_cnt                      <= byte_cnt + BYTE_CNT_W'(1);
      end
   end

   // High on the transfer that completes the word.
   assign word_ready_c = byte_valid && (byte_cnt == BYTE_CNT_W'(WORD_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// Fills the instruction memory from a byte stream while stalling the CPU.
// Define IMEM_LOADER_CHECKSUM_EN to verify a trailing XOR checksum word.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
   parameter int unsigned CNT_W  = ADDR_W + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] word_count,
   input  logic [7:0]       byte_in,
   input  logic             byte_valid,
   output logic             byte_ready,
   output logic             we,
   output logic [31:0]      waddr,
   output logic [31:0]      wdata,
   output logic             busy,
   output logic             cpu_stall,
   output logic             done,
   output logic             chk_err
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam logic [2:0] ST_AFTER_LAST = ST_CHK;
`else
   localparam logic [2:0] ST_AFTER_LAST = ST_DONE;
`endif

   logic [2:0]            state_q, state_d;
   logic [ADDR_W-1:0]     word_idx_q, word_idx_d;
   logic [CNT_W-1:0]      n_q, n_d, n_clamp_c;
   logic                  byte_ready_d, we_d, busy_d, done_d;
   logic                  xfer_c, start_acc_c, last_word_c, pk_clear_c;
   logic [WORD_W-1:0]     pk_word;
   logic                  pk_ready_c;
   logic [BYTE_CNT_W-1:0] pk_cnt;

   assign xfer_c      = byte_valid && byte_ready;
   assign start_acc_c = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
   assign n_clamp_c   = (word_count > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : word_count;
   assign last_word_c = (CNT_W'(word_idx_q) == (n_q - CNT_W'(1)));

   imem_loader_byte_packer u_packer (
      .clk          (clk),
      .rst          (rst),
      .clear        (pk_clear_c),
      .byte_in      (byte_in),
      .byte_valid   (xfer_c),
      .word         (pk_word),
      .word_ready_c (pk_ready_c),
      .byte_cnt     (pk_cnt)
   );

   // Next-state and registered-output decode.
   always_comb begin
      state_d    = state_q;
      word_idx_d = word_idx_q;
      n_d        = n_q;
      pk_clear_c = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               n_d        = n_clamp_c;
               word_idx_d = '0;
               pk_clear_c = 1'b1;
               state_d    = (n_clamp_c == '0) ? ST_DONE : ST_RECV;
            end
         end
         ST_RECV: begin
            if (xfer_c && pk_ready_c) state_d = ST_WRITE;
         end
         ST_WRITE: begin
            pk_clear_c = 1'b1;
            if (last_word_c) begin
               state_d = ST_AFTER_LAST;
            end else begin
               word_idx_d = word_idx_q + ADDR_W'(1);
               state_d    = ST_RECV;
            end
         end
         ST_CHK: begin
            if (xfer_c && pk_ready_c) state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
      byte_ready_d = (state_d == ST_RECV) || (state_d == ST_CHK);
      we_d         = (state_d == ST_WRITE);
      busy_d       = (state_d == ST_RECV) || (state_d == ST_WRITE) || (state_d == ST_CHK);
      done_d       = (state_d == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         word_idx_q <= '0;
         n_q        <= '0;
         byte_ready <= 1'b0;
         we         <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state_q    <= state_d;
         word_idx_q <= word_idx_d;
         n_q        <= n_d;
         byte_ready <= byte_ready_d;
         we         <= we_d;
         busy       <= busy_d;
         done       <= done_d;
      end
   end

   assign cpu_stall = busy;
   assign waddr     = 32'({word_idx_q, 2'b00});
   assign wdata     = pk_word;

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [WORD_W-1:0] chk_acc_q;
   logic [WORD_W-1:0] chk_word_c;
   logic              chk_done_c;

   // Expected checksum including the byte being accepted this cycle.
   always_comb begin
      chk_word_c                          = pk_word;
      chk_word_c[{pk_cnt, 3'b000} +: 8] = byte_in;
   end

   assign chk_done_c = (state_q == ST_CHK) && xfer_c && pk_ready_c;

   always_ff @(posedge clk) begin
      if (rst) begin
         chk_acc_q <= '0;
         chk_err   <= 1'b0;
      end else if (start_acc_c) begin
         chk_acc_q <= '0;
         chk_err   <= 1'b0;
      end else begin
         if (state_q == ST_WRITE) chk_acc_q <= chk_acc_q ^ pk_word;
         if (chk_done_c) chk_err <= (chk_word_c != chk_acc_q);
      end
   end
`else
   logic unused_cnt;
   assign unused_cnt = ^{pk_cnt, start_acc_c};
   assign chk_err    = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader; checksum cases build with
// IMEM_LOADER_CHECKSUM_EN.
module tb_imem_loader;

   localparam int unsigned ADDR_W = 6;
   localparam int unsigned CNT_W  = 7;

   logic             clk = 1'b0;
   logic             rst, start, byte_valid;
   logic [CNT_W-1:0] word_count;
   logic [7:0]       byte_in;
   logic             byte_ready, we, busy, cpu_stall, done, chk_err;
   logic [31:0]      waddr, wdata;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [7:0]  stream [0:299];
   logic [31:0] wr_addr [0:511];
   logic [31:0] wr_data [0:511];
   logic [31:0] mem [0:63];
   int          wr_n = 0;
   int          xfer_n = 0;
   int          done_cyc, stall_gap, ready_bad, fed;

   imem_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .word_count (word_count),
      .byte_in    (byte_in),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .we         (we),
      .waddr      (waddr),
      .wdata      (wdata),
      .busy       (busy),
      .cpu_stall  (cpu_stall),
      .done       (done),
      .chk_err    (chk_err)
   );

   always #5 clk = ~clk;

   // Write-port log and memory model.
   always @(posedge clk) begin
      if (we && wr_n < 512) begin
         wr_addr[wr_n]    = waddr;
         wr_data[wr_n]    = wdata;
         mem[waddr[7:2]]  = wdata;
         wr_n++;
      end
      if (byte_valid && byte_ready) xfer_n++;
   end

   task automatic apply_reset();
      rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00; word_count = '0;
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic do_start(input int count);
      start = 1'b1; word_count = CNT_W'(count);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic set_basic();
      logic [7:0] b [0:7];
      b = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
      for (int i = 0; i < 8; i++) stream[i] = b[i];
   endtask

   // Offers stream bytes until done (or until nbytes taken when stop_at_end);
   // cyc counts cycles with the start cycle as 0.
   task automatic feed(input int nbytes, input bit toggle, input bit stop_at_end);
      int idx = 0;
      int cyc = 1;
      bit ph = 1'b1;
      bit took;
      done_cyc = -1; stall_gap = 0; ready_bad = 0;
      while (cyc < 2001) begin
         if (done) begin
            done_cyc = cyc;
            break;
         end
         if (stop_at_end && idx == nbytes) break;
         if (cpu_stall !== 1'b1) stall_gap++;
         if (busy && !we && !byte_ready) ready_bad++;
         if (we && byte_ready) ready_bad++;
         byte_valid = (idx < nbytes) && (!toggle || ph);
         byte_in    = (idx < nbytes) ? stream[idx] : 8'h00;
         took       = byte_valid && byte_ready;
         @(posedge clk); #1;
         if (took) idx++;
         ph = !ph;
         cyc++;
      end
      byte_valid = 1'b0;
      fed = idx;
      if (cyc >= 2001) begin
         n_cmp++; n_bad++;
         $display("FAIL feed_timeout: got no done within %0d cycles, required done=1", cyc);
      end
   endtask

   task automatic test_reset();
      apply_reset();
      n_cmp++; if (byte_ready !== 1'b0) begin n_bad++; $display("FAIL rst_byte_ready: got %b want 0", byte_ready); end
      n_cmp++; if (we !== 1'b0) begin n_bad++; $display("FAIL rst_we: got %b want 0", we); end
      n_cmp++; if (waddr !== 32'h0) begin n_bad++; $display("FAIL rst_waddr: got %h want 0", waddr); end
      n_cmp++; if (wdata !== 32'h0) begin n_bad++; $display("FAIL rst_wdata: got %h want 0", wdata); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
      n_cmp++; if (cpu_stall !== 1'b0) begin n_bad++; $display("FAIL rst_cpu_stall: got %b want 0", cpu_stall); end
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", done); end
      n_cmp++; if (chk_err !== 1'b0) begin n_bad++; $display("FAIL rst_chk_err: got %b want 0", chk_err); end
   endtask

   task automatic check_basic_writes(input string tag, input int base);
      n_cmp++; if (wr_n - base !== 2) begin n_bad++; $display("FAIL %s_wr_count: got %0d want 2", tag, wr_n - base); end
      n_cmp++; if (wr_addr[base] !== 32'h0 || wr_data[base] !== 32'h12345678) begin
         n_bad++; $display("FAIL %s_word0: got %h/%h want 00000000/12345678", tag, wr_addr[base], wr_data[base]); end
      n_cmp++; if (wr_addr[base+1] !== 32'h4 || wr_data[base+1] !== 32'hDEADBEEF) begin
         n_bad++; $display("FAIL %s_word1: got %h/%h want 00000004/deadbeef", tag, wr_addr[base+1], wr_data[base+1]); end
      n_cmp++; if (fed !== 8) begin n_bad++; $display("FAIL %s_bytes_taken: got %0d want 8", tag, fed); end
      n_cmp++; if (ready_bad !== 0) begin n_bad++; $display("FAIL %s_ready_outside_write: got %0d want 0", tag, ready_bad); end
      n_cmp++; if (stall_gap !== 0) begin n_bad++; $display("FAIL %s_stall_gap: got %0d want 0", tag, stall_gap); end
   endtask

   task automatic test_back_to_back();
      int base;
      apply_reset(); set_basic();
      base = wr_n;
      do_start(2);
      feed(8, 1'b0, 1'b0);
      check_basic_writes("b2b", base);
      // start cycle, then 5 cycles per word, done registered after the last WRITE
      n_cmp++; if (done_cyc !== 11) begin n_bad++; $display("FAIL b2b_done_latency: got %0d want 11", done_cyc); end
      n_cmp++; if (mem[0] !== 32'h12345678 || mem[1] !== 32'hDEADBEEF) begin
         n_bad++; $display("FAIL b2b_mem: got %h %h want 12345678 deadbeef", mem[0], mem[1]); end
      n_cmp++; if (chk_err !== 1'b0 || busy !== 1'b0) begin
         n_bad++; $display("FAIL b2b_end_state: got chk_err=%b busy=%b want 0 0", chk_err, busy); end
   endtask

   task automatic test_valid_toggle();
      int base, x0;
      apply_reset(); set_basic();
      base = wr_n; x0 = xfer_n;
      do_start(2);
      feed(8, 1'b1, 1'b0);
      check_basic_writes("toggle", base);
      n_cmp++; if (xfer_n - x0 !== 8) begin n_bad++; $display("FAIL toggle_xfers: got %0d want 8", xfer_n - x0); end
   endtask

   task automatic test_zero_count();
      int base;
      bit busy_seen = 1'b0;
      apply_reset();
      base = wr_n;
      do_start(0);
      n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL zero_done: got %b want 1", done); end
      byte_valid = 1'b1; byte_in = 8'hAA;
      for (int i = 0; i < 4; i++) begin
         if (busy !== 1'b0 || byte_ready !== 1'b0) busy_seen = 1'b1;
         @(posedge clk); #1;
      end
      byte_valid = 1'b0;
      n_cmp++; if (busy_seen !== 1'b0) begin n_bad++; $display("FAIL zero_busy: got busy/ready asserted want 0"); end
      n_cmp++; if (wr_n - base !== 0) begin n_bad++; $display("FAIL zero_writes: got %0d want 0", wr_n - base); end
   endtask

   task automatic test_clamp();
      int base, x0, bad_words;
      logic [31:0] exp;
      apply_reset();
      for (int i = 0; i < 264; i++) stream[i] = 8'(i * 5 + 1);
      for (int k = 0; k < 64; k++) mem[k] = 32'h0;
      base = wr_n; x0 = xfer_n;
      do_start(100);
      feed(264, 1'b0, 1'b0);
      n_cmp++; if (wr_n - base !== 64) begin n_bad++; $display("FAIL clamp_wr_count: got %0d want 64", wr_n - base); end
      n_cmp++; if (wr_addr[base+63] !== 32'hFC) begin n_bad++; $display("FAIL clamp_last_addr: got %h want 000000fc", wr_addr[base+63]); end
      n_cmp++; if (fed !== 256) begin n_bad++; $display("FAIL clamp_bytes_taken: got %0d want 256", fed); end
      bad_words = 0;
      for (int k = 0; k < 64; k++) begin
         exp = {stream[4*k+3], stream[4*k+2], stream[4*k+1], stream[4*k]};
         if (mem[k] !== exp) bad_words++;
      end
      n_cmp++; if (bad_words !== 0) begin n_bad++; $display("FAIL clamp_mem: got %0d bad words want 0", bad_words); end
      byte_valid = 1'b1; byte_in = 8'h55;
      repeat (4) begin @(posedge clk); #1; end
      byte_valid = 1'b0;
      n_cmp++; if (xfer_n - x0 !== 256) begin n_bad++; $display("FAIL clamp_extra_bytes: got %0d xfers want 256", xfer_n - x0); end
   endtask

   task automatic test_reset_mid_load();
      int base;
      apply_reset(); set_basic();
      base = wr_n;
      do_start(2);
      feed(6, 1'b0, 1'b1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || byte_ready !== 1'b0) begin
         n_bad++; $display("FAIL midrst_state: got busy=%b done=%b ready=%b want 0 0 0", busy, done, byte_ready); end
      n_cmp++; if (wr_n - base !== 1) begin n_bad++; $display("FAIL midrst_partial_writes: got %0d want 1", wr_n - base); end
      stream[0] = 8'h01; stream[1] = 8'h02; stream[2] = 8'h03; stream[3] = 8'h04;
      base = wr_n;
      do_start(1);
      feed(4, 1'b0, 1'b0);
      n_cmp++; if (wr_n - base !== 1) begin n_bad++; $display("FAIL midrst_wr_count: got %0d want 1", wr_n - base); end
      n_cmp++; if (wr_addr[base] !== 32'h0 || wr_data[base] !== 32'h04030201) begin
         n_bad++; $display("FAIL midrst_word: got %h/%h want 00000000/04030201", wr_addr[base], wr_data[base]); end
      n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL midrst_done: got %b want 1", done); end
   endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
   task automatic test_checksum();
      int base;
      logic [31:0] sum;
      sum = 32'h12345678 ^ 32'hDEADBEEF;
      apply_reset(); set_basic();
      stream[8] = sum[7:0]; stream[9] = sum[15:8]; stream[10] = sum[23:16]; stream[11] = sum[31:24];
      base = wr_n;
      do_start(2);
      feed(12, 1'b0, 1'b0);
      n_cmp++; if (chk_err !== 1'b0 || done !== 1'b1) begin
         n_bad++; $display("FAIL chk_good: got chk_err=%b done=%b want 0 1", chk_err, done); end
      n_cmp++; if (wr_n - base !== 2 || fed !== 12) begin
         n_bad++; $display("FAIL chk_good_counts: got writes=%0d bytes=%0d want 2 12", wr_n - base, fed); end
      for (int i = 8; i < 12; i++) stream[i] = 8'h00;
      do_start(2);
      feed(12, 1'b0, 1'b0);
      n_cmp++; if (chk_err !== 1'b1 || done !== 1'b1) begin
         n_bad++; $display("FAIL chk_bad: got chk_err=%b done=%b want 1 1", chk_err, done); end
      do_start(2);
      n_cmp++; if (chk_err !== 1'b0) begin n_bad++; $display("FAIL chk_clear_on_start: got %b want 0", chk_err); end
      feed(12, 1'b0, 1'b0);
   endtask
`endif

   initial begin
      rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00; word_count = '0;
      test_reset();
      test_back_to_back();
      test_valid_toggle();
      test_zero_count();
      test_clamp();
      test_reset_mid_load();
`ifdef IMEM_LOADER_CHECKSUM_EN
      test_checksum();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
